dpu_cmd_arbiter: RTL and testbench
==================================

Name: dpu_cmd_arbiter

Overview:
- N-source arbiter for the dpu_top PIO command port. It generalises the fixed two-source DMA/AXI-Lite mux into N_SRC requesters.
- Arbitration mode is selectable: round-robin or fixed priority.
- A source can lock the port for a burst.
- Read responses are routed back to the issuing source only, with a response timeout.
- Sits between the AXI-Lite PIO FSM, the DMA engines and the core command/response interface.

Parameters:
N_SRC, 3, number of requesting sources (2..8)
ADDR_BITS, 24, command address width
CMD_W, 3, command type width
DATA_W, 8, command/response data width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest)
RSP_MASK, 8'b0001_0000, bit k set means cmd_type k expects a core response
TIMEOUT_CYC, 1024, cycles to wait for a response before error completion (>=2)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_cmd_valid  in  N_SRC  per-source command valid
s_cmd_ready  out  N_SRC  per-source command ready
s_cmd_type  in  N_SRC*CMD_W  packed command types, source i at [i*CMD_W +: CMD_W]
s_cmd_addr  in  N_SRC*ADDR_BITS  packed addresses
s_cmd_data  in  N_SRC*DATA_W  packed write data
s_lock  in  N_SRC  hold grant across commands while high
s_rsp_valid  out  N_SRC  one-hot response strobe to the issuing source
s_rsp_data  out  DATA_W  response data, shared by all sources
s_rsp_err  out  1  qualifies s_rsp_valid; 1 = timeout completion
m_cmd_valid  out  1  to core
m_cmd_ready  in  1  from core
m_cmd_type  out  CMD_W  to core
m_cmd_addr  out  ADDR_BITS  to core
m_cmd_data  out  DATA_W  to core
m_rsp_valid  in  1  core response strobe
m_rsp_data  in  DATA_W  core response data
grant  out  N_SRC  one-hot current owner, 0 when idle
busy  out  1  FSM not in IDLE
timeout_cnt  out  16  saturating count of timeouts

Behaviour:
- Reset (aresetn low at a clock edge):
  - FSM goes to IDLE; grant=0; round-robin pointer=0; timeout_cnt=0.
  - All outputs are 0, including m_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_err and s_rsp_data.
  - A reset mid-transaction abandons it; a late m_rsp_valid after reset is ignored.
- FSM states: IDLE, ACTIVE, WAIT_RSP.
- IDLE:
  - Request vector is req = s_cmd_valid | s_lock.
  - If req is nonzero, pick a winner and register grant; go to ACTIVE next cycle.
  - Round-robin picks the first set bit starting at the pointer and wrapping N_SRC-1 -> 0; the pointer then becomes (winner+1) mod N_SRC.
  - Fixed priority picks the lowest set index.
  - No command is forwarded in IDLE, so a new grant costs 1 bubble cycle.
- ACTIVE (owner g):
  - m_cmd_* is driven combinationally from source g; m_cmd_valid = s_cmd_valid[g].
  - s_cmd_ready[g] = m_cmd_ready; all other s_cmd_ready bits are 0.
  - On handshake with RSP_MASK[type]=1: go to WAIT_RSP and clear the timeout counter.
  - On handshake with RSP_MASK[type]=0: stay ACTIVE if s_lock[g], else go to IDLE.
  - If s_cmd_valid[g]=0 and s_lock[g]=0: go to IDLE (release).
- WAIT_RSP:
  - m_cmd_valid=0 and every s_cmd_ready bit is 0; the counter increments each cycle.
  - On m_rsp_valid: same cycle, s_rsp_valid[g]=1, s_rsp_data=m_rsp_data, s_rsp_err=0.
  - On counter == TIMEOUT_CYC-1 with no m_rsp_valid: s_rsp_valid[g]=1, s_rsp_err=1, s_rsp_data=0; timeout_cnt increments, saturating at 0xFFFF.
  - After either completion: go to ACTIVE if s_lock[g], else go to IDLE.
  - If m_rsp_valid coincides with the timeout cycle, the response wins (err=0, no count).
- m_rsp_valid outside WAIT_RSP is dropped (all s_rsp_valid bits stay 0).
- s_rsp_valid is always a single-cycle pulse; s_rsp_data is 0 when no strobe is active.
- Lock rules:
  - Lock is sampled only by the current owner.
  - Lock from non-owners counts as a request in IDLE only.
  - Dropping lock while ACTIVE with no valid releases the port next cycle.
- Simultaneous requests in IDLE: only one grant; losers stall with s_cmd_ready=0 and must hold their command stable.
- Writes to the core have no response path; completion is at handshake.

Test Plan:
1. Round-robin, all 3 sources issue one write (type 1) back-to-back continuously → grants rotate 0,1,2,0; each m_cmd handshake carries its source's addr/data; pointer wraps from 2 to 0.
2. ARB_MODE=1, sources 0 and 2 request continuously with lock low → source 0 wins every arbitration; source 2 is served only once source 0 drops valid.
3. Source 1 holds s_lock, issues 4 writes at addresses 0x10..0x13 while source 0 also requests → all 4 forwarded consecutively with grant=0b010 and no source-0 handshakes; source 0 is granted one bubble after lock drops.
4. Source 2 issues a read (type 4); core returns 0xA5 after 7 cycles → s_rsp_valid=0b100 for exactly 1 cycle, s_rsp_data=0xA5, s_rsp_err=0; then IDLE.
5. TIMEOUT_CYC=16, read with no core response → at cycle 16 s_rsp_valid to the owner, s_rsp_err=1, data=0, timeout_cnt=1; a stray m_rsp_valid 3 cycles later produces no s_rsp_valid.
6. aresetn low for 1 cycle while in WAIT_RSP → grant=0, busy=0, timeout_cnt=0 next cycle; arbitration resumes from pointer 0.

Source files
------------

// File: rtl/dpu_cmd_arbiter.sv
// N-source command arbiter for the dpu_top PIO port: round-robin or fixed
// priority, burst lock, response routing to the issuer with a timeout.

module dpu_cmd_arbiter_lane (
  input  logic i_own,
  input  logic i_act,
  input  logic i_rdy,
  input  logic i_rsp,
  output logic o_ready,
  output logic o_rsp_valid
);
  assign o_ready     = i_own & i_act & i_rdy;
  assign o_rsp_valid = i_own & i_rsp;
endmodule

module dpu_cmd_arbiter #(
  parameter int         N_SRC       = 3,
  parameter int         ADDR_BITS   = 24,
  parameter int         CMD_W       = 3,
  parameter int         DATA_W      = 8,
  parameter int         ARB_MODE    = 0,
  parameter logic [7:0] RSP_MASK    = 8'b0001_0000,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_SRC-1:0]           s_cmd_valid,
  output logic [N_SRC-1:0]           s_cmd_ready,
  input  logic [N_SRC*CMD_W-1:0]     s_cmd_type,
  input  logic [N_SRC*ADDR_BITS-1:0] s_cmd_addr,
  input  logic [N_SRC*DATA_W-1:0]    s_cmd_data,
  input  logic [N_SRC-1:0]           s_lock,
  output logic [N_SRC-1:0]           s_rsp_valid,
  output logic [DATA_W-1:0]          s_rsp_data,
  output logic                       s_rsp_err,
  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic [CMD_W-1:0]           m_cmd_type,
  output logic [ADDR_BITS-1:0]       m_cmd_addr,
  output logic [DATA_W-1:0]          m_cmd_data,
  input  logic                       m_rsp_valid,
  input  logic [DATA_W-1:0]          m_rsp_data,
  output logic [N_SRC-1:0]           grant,
  output logic                       busy,
  output logic [15:0]                timeout_cnt
);
  localparam int IW = $clog2(N_SRC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int MW = 1 << CMD_W;
  localparam logic [MW-1:0] RSP_M = MW'(RSP_MASK);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_WAIT} state_t;

  state_t             r_state, w_nxt;
  logic [N_SRC-1:0]   r_grant;
  logic [IW-1:0]      r_gidx, r_ptr, w_win, w_ptr_nxt;
  logic [IW:0]        w_cand;
  logic [TW-1:0]      r_tcnt;
  logic [15:0]        r_tocnt;
  logic [N_SRC-1:0]   w_req;
  logic               w_act, w_load, w_hs_rsp, w_tmo, w_rsp_fire, w_rsp_err;
  logic [DATA_W-1:0]  w_rsp_dat;
  logic               w_valid_g, w_lock_g;
  logic [CMD_W-1:0]   w_type_g;

  logic [CMD_W-1:0]     w_type_a [N_SRC];
  logic [ADDR_BITS-1:0] w_addr_a [N_SRC];
  logic [DATA_W-1:0]    w_data_a [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_lane
    assign w_type_a[i] = s_cmd_type[i*CMD_W +: CMD_W];
    assign w_addr_a[i] = s_cmd_addr[i*ADDR_BITS +: ADDR_BITS];
    assign w_data_a[i] = s_cmd_data[i*DATA_W +: DATA_W];
    dpu_cmd_arbiter_lane u_lane (
      .i_own       (r_grant[i]),
      .i_act       (w_act),
      .i_rdy       (m_cmd_ready),
      .i_rsp       (w_rsp_fire),
      .o_ready     (s_cmd_ready[i]),
      .o_rsp_valid (s_rsp_valid[i])
    );
  end

  assign w_req     = s_cmd_valid | s_lock;
  assign w_valid_g = s_cmd_valid[r_gidx];
  assign w_lock_g  = s_lock[r_gidx];
  assign w_type_g  = w_type_a[r_gidx];

  // Scan from the highest candidate down so the first candidate in order wins.
  always_comb begin
    w_win  = '0;
    w_cand = '0;
    for (int k = N_SRC-1; k >= 0; k--) begin
      w_cand = (ARB_MODE == 0) ? {1'b0, r_ptr} + (IW+1)'(k) : (IW+1)'(k);
      if (w_cand >= (IW+1)'(N_SRC)) w_cand = w_cand - (IW+1)'(N_SRC);
      if (w_req[w_cand[IW-1:0]]) w_win = w_cand[IW-1:0];
    end
  end

  assign w_ptr_nxt = (w_win == IW'(N_SRC-1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_nxt      = r_state;
    w_act      = 1'b0;
    w_load     = 1'b0;
    w_hs_rsp   = 1'b0;
    w_tmo      = 1'b0;
    w_rsp_fire = 1'b0;
    w_rsp_err  = 1'b0;
    w_rsp_dat  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_load = 1'b1;
          w_nxt  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        w_act = 1'b1;
        if (w_valid_g && m_cmd_ready) begin
          if (RSP_M[w_type_g]) begin
            w_hs_rsp = 1'b1;
            w_nxt    = ST_WAIT;
          end else if (!w_lock_g) begin
            w_nxt = ST_IDLE;
          end
        end else if (!w_valid_g && !w_lock_g) begin
          w_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A response arriving on the timeout cycle takes precedence.
        if (m_rsp_valid) begin
          w_rsp_fire = 1'b1;
          w_rsp_dat  = m_rsp_data;
        end else if (r_tcnt == TW'(TIMEOUT_CYC-1)) begin
          w_rsp_fire = 1'b1;
          w_rsp_err  = 1'b1;
          w_tmo      = 1'b1;
        end
        if (w_rsp_fire) w_nxt = w_lock_g ? ST_ACTIVE : ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_tcnt  <= '0;
      r_tocnt <= '0;
    end else begin
      if (w_load) begin
        r_grant <= N_SRC'(1) << w_win;
        r_gidx  <= w_win;
        if (ARB_MODE == 0) r_ptr <= w_ptr_nxt;
      end else if (w_nxt == ST_IDLE) begin
        r_grant <= '0;
      end
      if (w_hs_rsp)                r_tcnt <= '0;
      else if (r_state == ST_WAIT) r_tcnt <= r_tcnt + 1'b1;
      if (w_tmo && r_tocnt != 16'hFFFF) r_tocnt <= r_tocnt + 16'd1;
    end
  end

  assign m_cmd_valid = w_act & w_valid_g;
  assign m_cmd_type  = w_act ? w_type_g         : '0;
  assign m_cmd_addr  = w_act ? w_addr_a[r_gidx] : '0;
  assign m_cmd_data  = w_act ? w_data_a[r_gidx] : '0;
  assign s_rsp_data  = w_rsp_dat;
  assign s_rsp_err   = w_rsp_err;
  assign grant       = r_grant;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_cnt = r_tocnt;

endmodule

// File: tb/tb_dpu_cmd_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a transaction-level model.
module tb_dpu_cmd_arbiter;
  localparam int N = 3, AW = 24, CW = 3, DW = 8, TMO = 16;

  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [N-1:0]    src_v = '0, src_l = '0;
  logic [CW-1:0]   src_t [N];
  logic [AW-1:0]   src_a [N];
  logic [DW-1:0]   src_d [N];
  logic [N*CW-1:0] type_bus;
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] data_bus;
  logic            m_rdy = 1'b0, m_rv = 1'b0;
  logic [DW-1:0]   m_rd = '0;

  always_comb begin
    type_bus = '0; addr_bus = '0; data_bus = '0;
    for (int i = 0; i < N; i++) begin
      type_bus[i*CW +: CW] = src_t[i];
      addr_bus[i*AW +: AW] = src_a[i];
      data_bus[i*DW +: DW] = src_d[i];
    end
  end

  logic [N-1:0]  d_srdy [2], d_rspv [2], d_grant [2];
  logic [DW-1:0] d_rspd [2], d_mdata [2];
  logic          d_err [2], d_mv [2], d_busy [2];
  logic [CW-1:0] d_mtype [2];
  logic [AW-1:0] d_maddr [2];
  logic [15:0]   d_tocnt [2];

  dpu_cmd_arbiter #(.N_SRC(N), .ADDR_BITS(AW), .CMD_W(CW), .DATA_W(DW),
    .ARB_MODE(0), .RSP_MASK(8'b0001_0000), .TIMEOUT_CYC(TMO)) u_rr (
    .aclk(aclk), .aresetn(aresetn), .s_cmd_valid(src_v), .s_cmd_ready(d_srdy[0]),
    .s_cmd_type(type_bus), .s_cmd_addr(addr_bus), .s_cmd_data(data_bus), .s_lock(src_l),
    .s_rsp_valid(d_rspv[0]), .s_rsp_data(d_rspd[0]), .s_rsp_err(d_err[0]),
    .m_cmd_valid(d_mv[0]), .m_cmd_ready(m_rdy), .m_cmd_type(d_mtype[0]),
    .m_cmd_addr(d_maddr[0]), .m_cmd_data(d_mdata[0]), .m_rsp_valid(m_rv),
    .m_rsp_data(m_rd), .grant(d_grant[0]), .busy(d_busy[0]), .timeout_cnt(d_tocnt[0]));

  dpu_cmd_arbiter #(.N_SRC(N), .ADDR_BITS(AW), .CMD_W(CW), .DATA_W(DW),
    .ARB_MODE(1), .RSP_MASK(8'b0001_0000), .TIMEOUT_CYC(TMO)) u_fp (
    .aclk(aclk), .aresetn(aresetn), .s_cmd_valid(src_v), .s_cmd_ready(d_srdy[1]),
    .s_cmd_type(type_bus), .s_cmd_addr(addr_bus), .s_cmd_data(data_bus), .s_lock(src_l),
    .s_rsp_valid(d_rspv[1]), .s_rsp_data(d_rspd[1]), .s_rsp_err(d_err[1]),
    .m_cmd_valid(d_mv[1]), .m_cmd_ready(m_rdy), .m_cmd_type(d_mtype[1]),
    .m_cmd_addr(d_maddr[1]), .m_cmd_data(d_mdata[1]), .m_rsp_valid(m_rv),
    .m_rsp_data(m_rd), .grant(d_grant[1]), .busy(d_busy[1]), .timeout_cnt(d_tocnt[1]));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
  endtask

  // Model: owner index (-1 = port free), waiting for response, wait cycles,
  // round-robin pointer, timeout completions.
  int   own [2] = '{-1, -1};
  bit   wt  [2] = '{0, 0};
  int   wc  [2] = '{0, 0};
  int   ptr [2] = '{0, 0};
  int   toc [2] = '{0, 0};
  bit   go = 1'b0;
  bit [7:0] rspm = 8'b0001_0000;
  logic [N-1:0]  e_grant, e_srdy, e_rspv;
  logic          e_mv, e_err;
  logic [DW-1:0] e_rspd;
  int g, win, c;

  always @(negedge aclk) if (go) begin
    for (int k = 0; k < 2; k++) begin
      g = own[k];
      e_grant = '0; e_srdy = '0; e_rspv = '0; e_mv = 1'b0; e_err = 1'b0; e_rspd = '0;
      if (g >= 0) begin
        e_grant = N'(1 << g);
        if (!wt[k]) begin
          e_mv = src_v[g];
          if (m_rdy) e_srdy = N'(1 << g);
        end else if (m_rv) begin
          e_rspv = N'(1 << g); e_rspd = m_rd;
        end else if (wc[k] == TMO-1) begin
          e_rspv = N'(1 << g); e_err = 1'b1;
        end
      end
      chk("grant", k, 32'(d_grant[k]), 32'(e_grant));
      chk("busy", k, 32'(d_busy[k]), 32'(g >= 0));
      chk("m_cmd_valid", k, 32'(d_mv[k]), 32'(e_mv));
      chk("s_cmd_ready", k, 32'(d_srdy[k]), 32'(e_srdy));
      chk("s_rsp_valid", k, 32'(d_rspv[k]), 32'(e_rspv));
      chk("s_rsp_data", k, 32'(d_rspd[k]), 32'(e_rspd));
      chk("s_rsp_err", k, 32'(d_err[k]), 32'(e_err));
      chk("timeout_cnt", k, 32'(d_tocnt[k]), 32'(toc[k]));
      if (e_mv) begin
        chk("m_cmd_type", k, 32'(d_mtype[k]), 32'(src_t[g]));
        chk("m_cmd_addr", k, 32'(d_maddr[k]), 32'(src_a[g]));
        chk("m_cmd_data", k, 32'(d_mdata[k]), 32'(src_d[g]));
      end
      // state for the next cycle
      if (!aresetn) begin
        own[k] = -1; wt[k] = 0; wc[k] = 0; ptr[k] = 0; toc[k] = 0;
      end else if (g < 0) begin
        if ((src_v | src_l) != '0) begin
          win = -1;
          for (int j = 0; j < N; j++) begin
            c = (k == 0) ? (ptr[k] + j) % N : j;
            if (win < 0 && (src_v[c] || src_l[c])) win = c;
          end
          own[k] = win;
          ptr[k] = (win + 1) % N;
        end
      end else if (!wt[k]) begin
        if (src_v[g] && m_rdy) begin
          if (rspm[src_t[g]]) begin wt[k] = 1; wc[k] = 0; end
          else if (!src_l[g]) own[k] = -1;
        end else if (!src_v[g] && !src_l[g]) own[k] = -1;
      end else begin
        if (m_rv || wc[k] == TMO-1) begin
          if (!m_rv && toc[k] < 65535) toc[k]++;
          wt[k] = 0;
          if (!src_l[g]) own[k] = -1;
        end else wc[k]++;
      end
    end
  end

  task automatic cyc(); @(posedge aclk); #1; endtask
  task automatic drain(); src_v = '0; src_l = '0; repeat (3) cyc(); endtask

  logic [N-1:0] t1_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int t1_src [4] = '{0, 1, 2, 0};
  int hs, cnt0, cnt2;

  initial begin
    for (int i = 0; i < N; i++) begin
      src_t[i] = 3'd1; src_a[i] = 24'h100 + AW'(i); src_d[i] = 8'h30 + DW'(i);
    end
    repeat (2) cyc();
    go = 1'b1;
    // reset state, with a stray core response present
    m_rv = 1'b1; m_rd = 8'hEE;
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_grant", k, 32'(d_grant[k]), 0);
      chk("rst_busy", k, 32'(d_busy[k]), 0);
      chk("rst_rspv", k, 32'(d_rspv[k]), 0);
      chk("rst_rspd", k, 32'(d_rspd[k]), 0);
      chk("rst_tocnt", k, 32'(d_tocnt[k]), 0);
    end
    cyc();
    m_rv = 1'b0; aresetn = 1'b1; m_rdy = 1'b1;

    // 1: round-robin rotation over three writers
    src_v = 3'b111; hs = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge aclk);
      if (d_mv[0] && hs < 4) begin
        chk("t1_grant", 0, 32'(d_grant[0]), 32'(t1_seq[hs]));
        chk("t1_addr", 0, 32'(d_maddr[0]), 32'h100 + 32'(t1_src[hs]));
        hs++;
      end
      cyc();
    end
    chk("t1_handshakes", 0, 32'(hs), 4);
    drain();

    // 2: fixed priority, source 0 starves source 2 until it drops valid
    src_v = 3'b101; cnt0 = 0; cnt2 = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge aclk);
      if (d_mv[1] && d_grant[1] == 3'b001) cnt0++;
      if (d_mv[1] && d_grant[1] == 3'b100) cnt2++;
      cyc();
    end
    chk("t2_src0_hs", 1, 32'(cnt0), 4);
    chk("t2_src2_starved", 1, 32'(cnt2), 0);
    src_v = 3'b100; cnt2 = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge aclk);
      if (d_mv[1] && d_grant[1] == 3'b100) cnt2++;
      cyc();
    end
    chk("t2_src2_hs", 1, 32'(cnt2), 3);
    drain();

    // 3: locked burst from source 1 while source 0 waits
    src_l = 3'b010;
    cyc();
    for (int i = 0; i < 4; i++) begin
      src_v = 3'b011; src_a[1] = 24'h10 + AW'(i);
      @(negedge aclk);
      chk("t3_grant", 0, 32'(d_grant[0]), 3'b010);
      chk("t3_addr", 0, 32'(d_maddr[0]), 32'h10 + 32'(i));
      chk("t3_ready", 1, 32'(d_srdy[1]), 3'b010);
      cyc();
    end
    src_v = 3'b001; src_l = 3'b000;
    @(negedge aclk);
    chk("t3_release_mv", 0, 32'(d_mv[0]), 0);
    cyc();
    @(negedge aclk);
    chk("t3_bubble_grant", 0, 32'(d_grant[0]), 0);
    cyc();
    @(negedge aclk);
    chk("t3_src0_grant", 0, 32'(d_grant[0]), 3'b001);
    chk("t3_src0_grant", 1, 32'(d_grant[1]), 3'b001);
    cyc();
    drain();

    // 4: read from source 2, response after 7 cycles
    src_t[2] = 3'd4; src_a[2] = 24'h200; src_v = 3'b100;
    cyc();
    cyc();
    src_v = '0;
    for (int i = 0; i < 6; i++) begin @(negedge aclk); cyc(); end
    m_rv = 1'b1; m_rd = 8'hA5;
    @(negedge aclk);
    chk("t4_rspv", 0, 32'(d_rspv[0]), 3'b100);
    chk("t4_rspd", 0, 32'(d_rspd[0]), 8'hA5);
    chk("t4_err", 0, 32'(d_err[0]), 0);
    cyc();
    m_rv = 1'b0;
    @(negedge aclk);
    chk("t4_pulse", 0, 32'(d_rspv[0]), 0);
    chk("t4_idle", 0, 32'(d_busy[0]), 0);
    drain();

    // 5: read with no response times out on the 16th wait cycle
    src_t[0] = 3'd4; src_a[0] = 24'h300; src_v = 3'b001;
    cyc();
    cyc();
    src_v = '0;
    for (int i = 0; i < 15; i++) begin @(negedge aclk); cyc(); end
    @(negedge aclk);
    chk("t5_rspv", 0, 32'(d_rspv[0]), 3'b001);
    chk("t5_err", 0, 32'(d_err[0]), 1);
    chk("t5_rspd", 0, 32'(d_rspd[0]), 0);
    cyc();
    @(negedge aclk);
    chk("t5_tocnt", 0, 32'(d_tocnt[0]), 1);
    chk("t5_tocnt", 1, 32'(d_tocnt[1]), 1);
    cyc(); cyc();
    m_rv = 1'b1; m_rd = 8'h5A;
    @(negedge aclk);
    chk("t5_stray", 0, 32'(d_rspv[0]), 0);
    cyc();
    m_rv = 1'b0;
    drain();

    // 6: reset in the middle of a read
    src_t[1] = 3'd4; src_v = 3'b010;
    cyc();
    cyc();
    src_v = '0;
    cyc();
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1; m_rv = 1'b1; m_rd = 8'h77;
    @(negedge aclk);
    for (int k = 0; k < 2; k++) begin
      chk("t6_grant", k, 32'(d_grant[k]), 0);
      chk("t6_busy", k, 32'(d_busy[k]), 0);
      chk("t6_tocnt", k, 32'(d_tocnt[k]), 0);
      chk("t6_late_rsp", k, 32'(d_rspv[k]), 0);
    end
    cyc();
    m_rv = 1'b0;
    for (int i = 0; i < N; i++) src_t[i] = 3'd1;
    src_v = 3'b111;
    cyc();
    @(negedge aclk);
    chk("t6_ptr0", 0, 32'(d_grant[0]), 3'b001);
    cyc();
    drain();

    go = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
